mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage of the XYZ core, between EX and WB. Runs loads/stores as a Wishbone classic
//  data-bus master. Detects misaligned accesses and bus errors as traps. Stalls the pipe while a
//  bus cycle is open. Its registered outputs are the pipeline register that feeds the writeback stage.
// PARAMETERS
//  PASS_W   64   width of the opaque EX->WB control/data bundle (pc, pc4, rd, csr addr/data, mux_sel...)
// PORTS
//  clk_i            in   1       core clock
//  rst_i            in   1       asynchronous, active-low reset
//  mem_valid_ex_i   in   1       EX holds a valid instruction this cycle
//  mem_op_ex_i      in   4       [3]=access [2]=store [1]=unsigned [0]=unused; size in mem_size_ex_i
//  mem_size_ex_i    in   2       00 byte, 01 half, 10 word (11 reserved = word)
//  alu_ex_i         in   32      ALU result / effective address
//  store_data_ex_i  in   32      rs2 value for stores
//  trap_ex_i        in   1       trap already raised upstream
//  trap_code_ex_i   in   4       upstream trap cause
//  pass_ex_i        in   PASS_W  bundle copied to WB untouched; all-zero = NOP
//  flush_i          in   1       hazard unit kill of the EX instruction (trap/mret taken in WB)
//  stall_o          out  1       hold IF/ID/EX; high while an access is pending
//  dwbm_addr_o      out  32      word-aligned address {addr[31:2],2'b00}
//  dwbm_dat_o       out  32      lane-replicated store data
//  dwbm_sel_o       out  4       byte enables
//  dwbm_we_o        out  1       1 = write
//  dwbm_cyc_o       out  1       bus cycle
//  dwbm_stb_o       out  1       strobe (equal to cyc)
//  dwbm_dat_i       in   32      read data
//  dwbm_ack_i       in   1       cycle done
//  dwbm_err_i       in   1       bus error (takes priority over ack)
//  data_or_alu_wb_o out  32      extended load data, or ALU result
//  pass_wb_o        out  PASS_W  registered bundle
//  is_trap_wb_o     out  1       trap for WB
//  trap_code_wb_o   out  4       cause: 4 ld-misalign, 5 ld-fault, 6 st-misalign, 7 st-fault, else upstream
// BEHAVIOUR
//  - Reset (rst_i=0, async): state IDLE. All outputs 0, including cyc/stb/sel/we.
//  - FSM IDLE/BUS.
//    IDLE: if valid & access & !trap_ex & aligned & !flush: latch addr/data/sel/we/op and the bundle;
//      go BUS; stall_o=1 this cycle (comb).
//    BUS: cyc=stb=1 (registered), stall_o=1 until the cycle with ack|err.
//      In that cycle stall_o=0, the WB regs load the result, and the FSM returns to IDLE.
//  - Latency: issue cycle + >=1 bus cycle. With zero wait states stall_o is high for one cycle.
//  - Non-access, trapping, misaligned or flushed instructions never start a bus cycle. WB regs load
//    the same cycle (no stall).
//  - Alignment: half needs addr[0]=0; word needs addr[1:0]=0. Violation -> is_trap=1, code 4/6,
//    data_or_alu = address.
//  - err_i -> code 5/7, data_or_alu = address; err wins if asserted together with ack.
//  - Upstream trap_ex_i wins over all local checks; its code passes through.
//  - Stores: byte sel=1<<a[1:0], dat={4{b}}; half sel=a[1]?1100:0011, dat={2{h}}; word sel=1111.
//  - Loads: select lane by a[1:0]; sign- or zero-extend per op[1]; word unchanged.
//  - Bubble: any cycle the WB regs do not take a new instruction writes pass=0, is_trap=0. This
//    includes stall cycles and flush. WB never sees a repeat.
//  - flush_i in IDLE: bubble into WB. flush_i in BUS: a Wishbone cycle is never abandoned. cyc holds
//    until ack/err, then the result is dropped and a bubble is written.
//  - Inputs are sampled only in IDLE. The hazard unit holds EX stable while stall_o=1.
// STRUCTURE
//  - mem_pkg: op/size encodings, trap codes 4..7, PASS_W default, NOP bundle constant.
//  - Sub-module mem_align (combinational): sel and store-data steering, load extract and extend,
//    misalign detect. The FSM and the pipeline register stay in mem_stage.
// TESTING
//  1 lb from 0x1003, dat_i=0x80xxxxxx, 0 wait -> sel=1000, stall 1 cyc, data_or_alu=0xFFFFFF80.
//  2 sh 0xBEEF to 0x2002 -> sel=1100, we=1, dat=0xBEEFBEEF, pass_wb_o=bundle, is_trap=0.
//  3 lw 0x3001 -> no cyc, stall_o=0, is_trap=1, code=4, data_or_alu=0x3001.
//  4 sw 0x4000, err_i after 2 waits -> stall 3 cyc, code=7, bubbles during stall.
//  5 lhu 0x5000, 3 waits, flush_i in BUS -> cyc held to ack, then pass_wb_o=0, is_trap=0.
//  6 rst_i low mid-BUS -> cyc/stb/stall drop at once, all outputs 0. The next lw runs normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: op bits, access sizes, trap causes
// and the default width of the EX->WB pass-through bundle.
package mem_pkg;

   localparam int PASS_W_DEF = 64;
   localparam logic [PASS_W_DEF-1:0] PASS_NOP = '0;

   localparam int OP_ACCESS   = 3;
   localparam int OP_STORE    = 2;
   localparam int OP_UNSIGNED = 1;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam logic [3:0] TRAP_LD_MISALIGN = 4'd4;
   localparam logic [3:0] TRAP_LD_FAULT    = 4'd5;
   localparam logic [3:0] TRAP_ST_MISALIGN = 4'd6;
   localparam logic [3:0] TRAP_ST_FAULT    = 4'd7;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUS  = 1'b1;

endpackage

// File: rtl/mem_stage_if.sv
// Wishbone classic data-bus bundle between the memory stage (master) and the data memory (slave).
interface mem_stage_if;

   // Handshake: the master raises cyc=stb together with addr/dat_o/sel/we and holds all of
   // them stable until the slave returns ack or err for one cycle; err wins over ack.
   logic [31:0] addr;
   logic [31:0] dat_o;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic [31:0] dat_i;
   logic        ack;
   logic        err;

   modport master (
      output addr, dat_o, sel, we, cyc, stb,
      input  dat_i, ack, err
   );

   modport slave (
      input  addr, dat_o, sel, we, cyc, stb,
      output dat_i, ack, err
   );

endinterface

// File: rtl/mem_align.sv
// Byte-lane steering for the data bus: store select/replication and misalign detection on
// the issue side, lane extraction and sign/zero extension on the response side.
module mem_align
   import mem_pkg::*;
(
   input  logic [1:0]  i_st_addr_lo,
   input  logic [1:0]  i_st_size,
   input  logic [31:0] i_st_data,
   output logic [3:0]  o_sel,
   output logic [31:0] o_wdata,
   output logic        o_misalign,
   input  logic [1:0]  i_ld_addr_lo,
   input  logic [1:0]  i_ld_size,
   input  logic        i_ld_unsigned,
   input  logic [31:0] i_ld_raw,
   output logic [31:0] o_ld_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      o_misalign = 1'b0;
      o_sel      = 4'b1111;
      o_wdata    = i_st_data;
      case (i_st_size)
         SZ_BYTE: begin
            o_sel   = 4'b0001 << i_st_addr_lo;
            o_wdata = {4{i_st_data[7:0]}};
         end
         SZ_HALF: begin
            o_misalign = i_st_addr_lo[0];
            o_sel      = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata    = {2{i_st_data[15:0]}};
         end
         // The reserved size code behaves as a word access.
         default: begin
            o_misalign = (i_st_addr_lo != 2'b00);
         end
      endcase
   end

   always_comb begin
      case (i_ld_addr_lo)
         2'd0:    w_byte = i_ld_raw[7:0];
         2'd1:    w_byte = i_ld_raw[15:8];
         2'd2:    w_byte = i_ld_raw[23:16];
         default: w_byte = i_ld_raw[31:24];
      endcase
      w_half = i_ld_addr_lo[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];
   end

   always_comb begin
      case (i_ld_size)
         SZ_BYTE: o_ld_data = i_ld_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
         SZ_HALF: o_ld_data = i_ld_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
         default: o_ld_data = i_ld_raw;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores as a Wishbone classic master, raises misalign and
// bus-fault traps, stalls the front of the pipe while a cycle is open, and owns the MEM/WB register.
module mem_stage
   import mem_pkg::*;
#(
   parameter int PASS_W = PASS_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mem_valid_ex_i,
   input  logic [3:0]        mem_op_ex_i,
   input  logic [1:0]        mem_size_ex_i,
   input  logic [31:0]       alu_ex_i,
   input  logic [31:0]       store_data_ex_i,
   input  logic              trap_ex_i,
   input  logic [3:0]        trap_code_ex_i,
   input  logic [PASS_W-1:0] pass_ex_i,
   input  logic              flush_i,
   output logic              stall_o,
   mem_stage_if.master       dwbm,
   output logic [31:0]       data_or_alu_wb_o,
   output logic [PASS_W-1:0] pass_wb_o,
   output logic              is_trap_wb_o,
   output logic [3:0]        trap_code_wb_o,
   output logic [0:0]        state_o
);

   logic [0:0]        r_state;
   logic [31:0]       r_addr;
   logic [1:0]        r_size;
   logic              r_uns;
   logic              r_we;
   logic [3:0]        r_sel;
   logic [31:0]       r_dat;
   logic              r_cyc;
   logic              r_kill;
   logic [PASS_W-1:0] r_pass;

   logic [31:0]       r_data_wb;
   logic [PASS_W-1:0] r_pass_wb;
   logic              r_trap_wb;
   logic [3:0]        r_code_wb;

   logic              w_access;
   logic              w_store;
   logic              w_uns;
   logic              w_unused_op0;
   logic [3:0]        w_sel;
   logic [31:0]       w_wdata;
   logic              w_misalign;
   logic [31:0]       w_ld_data;
   logic              w_start;
   logic              w_done;

   logic [PASS_W-1:0] w_pass_nxt;
   logic              w_trap_nxt;
   logic [3:0]        w_code_nxt;
   logic [31:0]       w_data_nxt;

   assign w_access     = mem_op_ex_i[OP_ACCESS];
   assign w_store      = mem_op_ex_i[OP_STORE];
   assign w_uns        = mem_op_ex_i[OP_UNSIGNED];
   assign w_unused_op0 = mem_op_ex_i[0];

   mem_align u_align (
      .i_st_addr_lo  (alu_ex_i[1:0]),
      .i_st_size     (mem_size_ex_i),
      .i_st_data     (store_data_ex_i),
      .o_sel         (w_sel),
      .o_wdata       (w_wdata),
      .o_misalign    (w_misalign),
      .i_ld_addr_lo  (r_addr[1:0]),
      .i_ld_size     (r_size),
      .i_ld_unsigned (r_uns),
      .i_ld_raw      (dwbm.dat_i),
      .o_ld_data     (w_ld_data)
   );

   assign w_start = (r_state == S_IDLE) && mem_valid_ex_i && w_access && !trap_ex_i &&
                    !w_misalign && !flush_i;
   assign w_done  = (r_state == S_BUS) && (dwbm.ack || dwbm.err);

   // Gated by reset so the front of the pipe is released the moment reset asserts.
   assign stall_o = rst_i && ((r_state == S_IDLE) ? w_start : !(dwbm.ack || dwbm.err));

   always_comb begin
      w_pass_nxt = '0;
      w_trap_nxt = 1'b0;
      w_code_nxt = 4'd0;
      w_data_nxt = 32'd0;
      if (r_state == S_IDLE) begin
         if (mem_valid_ex_i && !flush_i && !w_start) begin
            w_pass_nxt = pass_ex_i;
            w_data_nxt = alu_ex_i;
            if (trap_ex_i) begin
               w_trap_nxt = 1'b1;
               w_code_nxt = trap_code_ex_i;
            end else if (w_access && w_misalign) begin
               w_trap_nxt = 1'b1;
               w_code_nxt = w_store ? TRAP_ST_MISALIGN : TRAP_LD_MISALIGN;
            end
         end
      end else if (w_done && !r_kill && !flush_i) begin
         w_pass_nxt = r_pass;
         if (dwbm.err) begin
            w_trap_nxt = 1'b1;
            w_code_nxt = r_we ? TRAP_ST_FAULT : TRAP_LD_FAULT;
            w_data_nxt = r_addr;
         end else begin
            w_data_nxt = r_we ? r_addr : w_ld_data;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_addr  <= 32'd0;
         r_size  <= 2'd0;
         r_uns   <= 1'b0;
         r_we    <= 1'b0;
         r_sel   <= 4'd0;
         r_dat   <= 32'd0;
         r_cyc   <= 1'b0;
         r_kill  <= 1'b0;
         r_pass  <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_start) begin
            r_state <= S_BUS;
            r_addr  <= alu_ex_i;
            r_size  <= mem_size_ex_i;
            r_uns   <= w_uns;
            r_we    <= w_store;
            r_sel   <= w_sel;
            r_dat   <= w_wdata;
            r_cyc   <= 1'b1;
            r_kill  <= 1'b0;
            r_pass  <= pass_ex_i;
         end
      end else if (w_done) begin
         r_state <= S_IDLE;
         r_we    <= 1'b0;
         r_sel   <= 4'd0;
         r_cyc   <= 1'b0;
         r_kill  <= 1'b0;
      end else if (flush_i) begin
         // The open cycle must still complete; only its result is discarded.
         r_kill  <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_data_wb <= 32'd0;
         r_pass_wb <= '0;
         r_trap_wb <= 1'b0;
         r_code_wb <= 4'd0;
      end else begin
         r_data_wb <= w_data_nxt;
         r_pass_wb <= w_pass_nxt;
         r_trap_wb <= w_trap_nxt;
         r_code_wb <= w_code_nxt;
      end
   end

   assign dwbm.addr  = {r_addr[31:2], 2'b00};
   assign dwbm.dat_o = r_dat;
   assign dwbm.sel   = r_sel;
   assign dwbm.we    = r_we;
   assign dwbm.cyc   = r_cyc;
   assign dwbm.stb   = r_cyc;

   assign data_or_alu_wb_o = r_data_wb;
   assign pass_wb_o        = r_pass_wb;
   assign is_trap_wb_o     = r_trap_wb;
   assign trap_code_wb_o   = r_code_wb;
   assign state_o          = r_state;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table of load/store vectors driven through a Wishbone responder,
// WB results checked against an expected queue, plus reset-mid-cycle and random word loads.
module tb_mem_stage;
   import mem_pkg::*;

   localparam int W = 64 + 1 + 4 + 32;

   logic        clk;
   logic        rst_n;
   logic        valid;
   logic [3:0]  op;
   logic [1:0]  size;
   logic [31:0] alu;
   logic [31:0] sdata;
   logic        trap_ex;
   logic [3:0]  tcode;
   logic [63:0] pass;
   logic        flush;
   logic        stall;
   logic [31:0] data_wb;
   logic [63:0] pass_wb;
   logic        trap_wb;
   logic [3:0]  code_wb;
   logic [0:0]  state;

   mem_stage_if bus ();

   mem_stage dut (
      .clk_i            (clk),
      .rst_i            (rst_n),
      .mem_valid_ex_i   (valid),
      .mem_op_ex_i      (op),
      .mem_size_ex_i    (size),
      .alu_ex_i         (alu),
      .store_data_ex_i  (sdata),
      .trap_ex_i        (trap_ex),
      .trap_code_ex_i   (tcode),
      .pass_ex_i        (pass),
      .flush_i          (flush),
      .stall_o          (stall),
      .dwbm             (bus),
      .data_or_alu_wb_o (data_wb),
      .pass_wb_o        (pass_wb),
      .is_trap_wb_o     (trap_wb),
      .trap_code_wb_o   (code_wb),
      .state_o          (state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [3:0]  op;
      logic [1:0]  size;
      logic [31:0] alu;
      logic [31:0] sdata;
      logic        trap_ex;
      logic [3:0]  tcode;
      logic [63:0] pass;
      logic        flush_idle;
      logic        flush_bus;
      int          waits;
      logic        err;
      logic        ack_too;
      logic [31:0] rdata;
      logic        start;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        push;
      logic        trap;
      logic [3:0]  code;
      logic [31:0] data;
   } vec_t;

   logic [W-1:0] exp_q[$];
   int n_pass  = 0;
   int n_total = 0;
   vec_t vecs[17];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
   endtask

   // scoreboard: every non-bubble WB value must match the oldest expected result
   always @(negedge clk) begin
      if (rst_n && (pass_wb !== PASS_NOP || trap_wb !== 1'b0)) begin
         if (exp_q.size() == 0) begin
            chk("wb_unexpected", {pass_wb, trap_wb, code_wb, data_wb}, '0);
         end else begin
            chk("wb_result", {pass_wb, trap_wb, code_wb, data_wb}, exp_q.pop_front());
         end
      end
   end

   // driver: one EX instruction plus the Wishbone responder for it; starts at posedge+1
   task automatic do_op(input vec_t v);
      valid   = 1'b1;
      op      = v.op;
      size    = v.size;
      alu     = v.alu;
      sdata   = v.sdata;
      trap_ex = v.trap_ex;
      tcode   = v.tcode;
      pass    = v.pass;
      flush   = v.flush_idle;
      if (v.push) exp_q.push_back({v.pass, v.trap, v.code, v.data});
      #1;
      chk({v.nm, "_stall_issue"}, stall, v.start);
      chk({v.nm, "_cyc_issue"}, bus.cyc, 1'b0);
      @(posedge clk); #1;
      flush = 1'b0;
      if (v.start) begin
         chk({v.nm, "_cyc"}, {bus.cyc, bus.stb}, 2'b11);
         chk({v.nm, "_sel"}, bus.sel, v.sel);
         chk({v.nm, "_dat"}, bus.dat_o, v.dat);
         chk({v.nm, "_we_addr"}, {bus.we, bus.addr}, {v.op[2], v.alu[31:2], 2'b00});
         for (int w = 0; w < v.waits; w++) begin
            flush = v.flush_bus && (w == 0);
            #1;
            chk({v.nm, "_stall_wait"}, {stall, bus.cyc}, 2'b11);
            chk({v.nm, "_wb_bubble"}, {pass_wb, trap_wb}, '0);
            @(posedge clk); #1;
            flush = 1'b0;
         end
         bus.dat_i = v.rdata;
         bus.err   = v.err;
         bus.ack   = v.err ? v.ack_too : 1'b1;
         #1;
         chk({v.nm, "_stall_done"}, {stall, bus.cyc}, 2'b01);
         @(posedge clk); #1;
         bus.ack = 1'b0;
         bus.err = 1'b0;
         chk({v.nm, "_cyc_release"}, {bus.cyc, state}, 2'b00);
      end
      valid = 1'b0;
   endtask

   initial begin
      vec_t v;
      rst_n = 1'b0; valid = 1'b1; op = 4'h8; size = SZ_WORD; alu = 32'h100; sdata = '0;
      trap_ex = 1'b0; tcode = '0; pass = 64'h1; flush = 1'b0;
      bus.dat_i = '0; bus.ack = 1'b0; bus.err = 1'b0;

      //         nm              op    sz   alu          sdata        tx tc  pass   fi fb w  er at rdata         st sel      dat           pu tr code data
      vecs[0]  = '{"lb_1003",    4'h8, 2'd0, 32'h1003, 32'h0,        0, 0, 64'h11, 0, 0, 0, 0, 0, 32'h80AABBCC, 1, 4'b1000, 32'h0,        1, 0, 4'd0, 32'hFFFFFF80};
      vecs[1]  = '{"sh_2002",    4'hC, 2'd1, 32'h2002, 32'h1234BEEF, 0, 0, 64'h22, 0, 0, 1, 0, 0, 32'h0,        1, 4'b1100, 32'hBEEFBEEF, 1, 0, 4'd0, 32'h2002};
      vecs[2]  = '{"lw_3001",    4'h8, 2'd2, 32'h3001, 32'h0,        0, 0, 64'h33, 0, 0, 0, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        1, 1, 4'd4, 32'h3001};
      vecs[3]  = '{"sw_4000_err",4'hC, 2'd2, 32'h4000, 32'hCAFEF00D, 0, 0, 64'h44, 0, 0, 2, 1, 0, 32'h0,        1, 4'b1111, 32'hCAFEF00D, 1, 1, 4'd7, 32'h4000};
      vecs[4]  = '{"lhu_flush",  4'hA, 2'd1, 32'h5000, 32'h0,        0, 0, 64'h55, 0, 1, 3, 0, 0, 32'h1234,     1, 4'b0011, 32'h0,        0, 0, 4'd0, 32'h0};
      vecs[5]  = '{"alu_op",     4'h0, 2'd0, 32'h12345678, 32'h0,    0, 0, 64'h66, 0, 0, 0, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        1, 0, 4'd0, 32'h12345678};
      vecs[6]  = '{"up_trap",    4'h8, 2'd2, 32'h1,    32'h0,        1, 2, 64'h77, 0, 0, 0, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        1, 1, 4'd2, 32'h1};
      vecs[7]  = '{"sb_6001",    4'hC, 2'd0, 32'h6001, 32'hFFFFFF77, 0, 0, 64'h88, 0, 0, 0, 0, 0, 32'h0,        1, 4'b0010, 32'h77777777, 1, 0, 4'd0, 32'h6001};
      vecs[8]  = '{"lh_7002",    4'h8, 2'd1, 32'h7002, 32'h0,        0, 0, 64'h99, 0, 0, 0, 0, 0, 32'h80011234, 1, 4'b1100, 32'h0,        1, 0, 4'd0, 32'hFFFF8001};
      vecs[9]  = '{"lhu_7000",   4'hA, 2'd1, 32'h7000, 32'h0,        0, 0, 64'hAA, 0, 0, 2, 0, 0, 32'h8001F00D, 1, 4'b0011, 32'h0,        1, 0, 4'd0, 32'h0000F00D};
      vecs[10] = '{"lbu_8001",   4'hA, 2'd0, 32'h8001, 32'h0,        0, 0, 64'hBB, 0, 0, 1, 0, 0, 32'h0000AB00, 1, 4'b0010, 32'h0,        1, 0, 4'd0, 32'h000000AB};
      vecs[11] = '{"lw_9000",    4'h8, 2'd2, 32'h9000, 32'h0,        0, 0, 64'hCC, 0, 0, 1, 0, 0, 32'hDEADBEEF, 1, 4'b1111, 32'h0,        1, 0, 4'd0, 32'hDEADBEEF};
      vecs[12] = '{"sh_a001",    4'hC, 2'd1, 32'hA001, 32'h1,        0, 0, 64'hDD, 0, 0, 0, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        1, 1, 4'd6, 32'hA001};
      vecs[13] = '{"lb_b002_err",4'h8, 2'd0, 32'hB002, 32'h0,        0, 0, 64'hEE, 0, 0, 0, 1, 0, 32'h0,        1, 4'b0100, 32'h0,        1, 1, 4'd5, 32'hB002};
      vecs[14] = '{"lw_flush_id",4'h8, 2'd2, 32'hC000, 32'h0,        0, 0, 64'hF1, 1, 0, 0, 0, 0, 32'h0,        0, 4'b0000, 32'h0,        0, 0, 4'd0, 32'h0};
      vecs[15] = '{"lw_rsvd_sz", 4'h8, 2'd3, 32'hD000, 32'h0,        0, 0, 64'hF2, 0, 0, 0, 0, 0, 32'h01020304, 1, 4'b1111, 32'h0,        1, 0, 4'd0, 32'h01020304};
      vecs[16] = '{"lw_err_ack", 4'h8, 2'd2, 32'hE000, 32'h0,        0, 0, 64'hF3, 0, 0, 1, 1, 1, 32'h55555555, 1, 4'b1111, 32'h0,        1, 1, 4'd5, 32'hE000};

      // reset state with a startable load presented on EX
      #13;
      chk("rst_stall", stall, 1'b0);
      chk("rst_bus", {bus.cyc, bus.stb, bus.sel, bus.we, bus.addr, bus.dat_o}, '0);
      chk("rst_wb", {pass_wb, trap_wb, code_wb, data_wb, state}, '0);
      valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 17; i++) do_op(vecs[i]);

      // reset asserted while a bus cycle is open
      valid = 1'b1; op = 4'h8; size = SZ_WORD; alu = 32'hF000; pass = 64'h123;
      @(posedge clk); #1;
      chk("rstmid_open", {bus.cyc, stall}, 2'b11);
      rst_n = 1'b0;
      #1;
      chk("rstmid_bus", {bus.cyc, bus.stb, bus.sel, bus.we, bus.addr, stall}, '0);
      chk("rstmid_wb", {pass_wb, trap_wb, code_wb, data_wb, state}, '0);
      valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      v = vecs[11];
      v.nm = "lw_after_rst"; v.pass = 64'h456; v.waits = 0; v.rdata = 32'h0BADF00D; v.data = 32'h0BADF00D;
      do_op(v);

      // random aligned word loads with random wait states
      for (int i = 0; i < 6; i++) begin
         v = vecs[11];
         v.nm    = "lw_rand";
         v.alu   = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         v.pass  = 64'h1000 + 64'(i);
         v.waits = $urandom_range(0, 3);
         v.rdata = $urandom;
         v.data  = v.rdata;
         do_op(v);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
